// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and glyph constants for the 4-digit 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}; all glyphs and anode codes are active-low.
package seg7_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Active-low one-hot anode for a digit slot; an[0] is the minutes-units digit.
    function automatic logic [3:0] an_sel(input dig_state_e s);
        return ~(4'b0001 << s);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side signal bundle between the clock/alarm core and the scan driver.
// master = clock core side (drives digits/alarm/mode), slave = scan driver.
interface seg7_scan_driver_if;
    logic [3:0] min_LSB;
    logic [3:0] min_MSB;
    logic [3:0] hr_LSB;
    logic [3:0] hr_MSB;
    logic       alarm;
    logic [1:0] mode;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    modport master (
        output min_LSB, min_MSB, hr_LSB, hr_MSB, alarm, mode,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  min_LSB, min_MSB, hr_LSB, hr_MSB, alarm, mode,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Glyph lookup; non-decimal codes fall through to the dash.
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode 7-segment scan driver.
// Digits are snapshotted once per frame (DIG3->DIG0) so a frame never mixes two times.
// Each slot starts with GUARD_CYC cycles of all anodes off to stop ghosting, and a
// zero hours-tens digit is suppressed. Optional macro SEG7_BLINK_EN adds a frame
// counter that blanks the whole display on alternate blink half-periods in alarm-set mode.
//
// state | meaning
// DIG0  | minutes units shown (an[0])
// DIG1  | minutes tens shown  (an[1])
// DIG2  | hours units shown   (an[2]), decimal point carries alarm flag
// DIG3  | hours tens shown    (an[3]), blank when zero; reset state
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 25_000,
    parameter int GUARD_CYC    = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                clk,
    input  logic                clr_n,
    seg7_scan_driver_if.slave   disp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0]   presc_q, presc_d;
    logic            slot_tick;
    logic            snap;
    dig_state_e      state_q, state_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0]      digit_sel;
    logic [6:0]      glyph;
    logic            dark;

    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            dp_q, dp_d;
    logic            ft_q, ft_d;

    // Slot prescaler: free-running 0..REFRESH_DIV-1.
    always_comb begin
        slot_tick = (presc_q == PW'(REFRESH_DIV - 1));
        presc_d   = slot_tick ? '0 : presc_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    // Digit sequencer next state; the DIG3->DIG0 step is the snapshot instant.
    always_comb begin
        state_d = state_q;
        snap    = 1'b0;
        if (slot_tick) begin
            case (state_q)
                DIG0: state_d = DIG1;
                DIG1: state_d = DIG2;
                DIG2: state_d = DIG3;
                DIG3: begin
                    state_d = DIG0;
                    snap    = 1'b1;
                end
                default: state_d = DIG3;
            endcase
        end
    end

    // Digit sequencer state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= DIG3;
        else        state_q <= state_d;
    end

    // Shadow digits: index 0 = minutes units ... 3 = hours tens.
    always_comb begin
        shadow_d = shadow_q;
        if (snap) shadow_d = {disp.hr_MSB, disp.hr_LSB, disp.min_MSB, disp.min_LSB};
    end

    // Shadow register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) shadow_q <= '0;
        else        shadow_q <= shadow_d;
    end

    // Decode from next-state values so the registered outputs line up with the slot.
    assign digit_sel = shadow_d[state_d];

    bcd_to_seg7 u_dec (
        .bcd_i (digit_sel),
        .seg_o (glyph)
    );

`ifdef SEG7_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    // Blink phase flips every BLINK_FRAMES snapshots, independent of mode.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (snap) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // mode is live, so leaving alarm-set restores the display on the next cycle.
    assign dark = (disp.mode == 2'b01) && blink_d;
`else
    logic unused_mode;
    assign unused_mode = ^disp.mode;
    assign dark        = 1'b0;
`endif

    // Next output values: guard, leading-zero and blink all force anodes off.
    always_comb begin
        seg_d = glyph;
        dp_d  = ~((state_d == DIG2) && disp.alarm);
        ft_d  = snap;
        an_d  = an_sel(state_d);
        if ((presc_d < PW'(GUARD_CYC)) || dark ||
            ((state_d == DIG3) && (shadow_d[3] == 4'd0))) begin
            an_d = AN_OFF;
        end
    end

    // Output registers; reset blanks the display asynchronously.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
            dp_q  <= 1'b1;
            ft_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
            ft_q  <= ft_d;
        end
    end

    assign disp.seg        = seg_q;
    assign disp.an         = an_q;
    assign disp.dp         = dp_q;
    assign disp.frame_tick = ft_q;

endmodule
